// File: rtl/order_gen.sv
// ---------------------------------------------------------------------------
// order_gen
// Output-stage order generator for the trading pipeline. Each accepted
// (signal, allow_trade, kill_switch) beat becomes at most one buy or sell
// order. The block tracks a signed Q16.16 net position, keeps it within
// +/-POS_LIMIT, drops beats during a post-order cooldown, and latches a halt
// when a kill request is seen.
//
// Optional build macro: ORDER_STATS_EN adds the ord_count / drop_count
// saturating statistics outputs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake (in_ready depends on state only)
//   signal_in             signed Q16.16 trading signal
//   allow_trade           risk permission for the beat
//   kill_switch           risk kill request for the beat
//   ord_valid/ord_ready   order handshake
//   ord_side              1 = buy, 0 = sell
//   ord_qty               order quantity, Q16.16
//   position_out          signed Q16.16 net position
//   halted                high while halted
//   clear_halt            single-cycle pulse that releases the halt
//   ord_count             (ORDER_STATS_EN) completed order handshakes
//   drop_count            (ORDER_STATS_EN) accepted beats producing no order
// ---------------------------------------------------------------------------
module order_gen #(
   parameter logic signed [31:0] THRESH    = 32'sh0000_8000,
   parameter logic signed [31:0] ORDER_QTY = 32'sh0001_0000,
   parameter logic signed [31:0] POS_LIMIT = 32'sh000A_0000,
   parameter int unsigned        COOLDOWN  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] signal_in,
   input  logic               allow_trade,
   input  logic               kill_switch,
   output logic               ord_valid,
   input  logic               ord_ready,
   output logic               ord_side,
   output logic        [31:0] ord_qty,
   output logic signed [31:0] position_out,
   output logic               halted,
   input  logic               clear_halt
`ifdef ORDER_STATS_EN
   ,
   output logic        [15:0] ord_count,
   output logic        [15:0] drop_count
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_COOL = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   // 33-bit copies so negation and +/- quantity can never overflow
   localparam logic signed [32:0] THRESH_X     = 33'(THRESH);
   localparam logic signed [32:0] NEG_THRESH_X = -THRESH_X;
   localparam logic signed [32:0] QTY_X        = 33'(ORDER_QTY);
   localparam logic signed [32:0] LIM_X        = 33'(POS_LIMIT);
   localparam logic signed [32:0] NEG_LIM_X    = -LIM_X;
   localparam logic        [15:0] CD_LOAD      = 16'(COOLDOWN);
   localparam bit                 CD_EN        = (COOLDOWN != 32'd0);

   logic [1:0]         state_r,   state_nx_s;
   logic [15:0]        cnt_r,     cnt_nx_s;
   logic signed [31:0] pos_r,     pos_nx_s;
   logic               side_r,    side_nx_s;
   logic [31:0]        qty_r,     qty_nx_s;
   logic               ord_valid_r;
   logic               halted_r;
   logic               in_ready_r;

   logic               accept_s;
   logic               done_s;
   logic               drop_s;
   logic signed [32:0] sig_x_s;
   logic signed [32:0] pos_x_s;
   logic signed [32:0] pos_up_s;
   logic signed [32:0] pos_dn_s;
   logic               buy_ok_s;
   logic               sell_ok_s;

   assign accept_s     = in_valid && in_ready_r;
   assign in_ready     = in_ready_r;
   assign ord_valid    = ord_valid_r;
   assign ord_side     = side_r;
   assign ord_qty      = qty_r;
   assign position_out = pos_r;
   assign halted       = halted_r;

   // Widened signal/position arithmetic and the buy/sell eligibility tests
   always_comb begin
      sig_x_s   = 33'(signal_in);
      pos_x_s   = 33'(pos_r);
      pos_up_s  = pos_x_s + QTY_X;
      pos_dn_s  = pos_x_s - QTY_X;
      buy_ok_s  = allow_trade && (sig_x_s > THRESH_X)     && (pos_up_s <= LIM_X);
      sell_ok_s = allow_trade && (sig_x_s < NEG_THRESH_X) && (pos_dn_s >= NEG_LIM_X);
   end

   // Next-state, order latch, position and cooldown counter decisions
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      pos_nx_s   = pos_r;
      side_nx_s  = side_r;
      qty_nx_s   = qty_r;
      done_s     = 1'b0;
      drop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (kill_switch) begin
                  state_nx_s = ST_HALT;
                  drop_s     = 1'b1;
               end else if (buy_ok_s) begin
                  state_nx_s = ST_EMIT;
                  side_nx_s  = 1'b1;
                  qty_nx_s   = ORDER_QTY;
               end else if (sell_ok_s) begin
                  state_nx_s = ST_EMIT;
                  side_nx_s  = 1'b0;
                  qty_nx_s   = ORDER_QTY;
               end else begin
                  drop_s     = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (ord_ready) begin
               done_s = 1'b1;
               if (side_r) begin
                  pos_nx_s = pos_up_s[31:0];
               end else begin
                  pos_nx_s = pos_dn_s[31:0];
               end
               if (CD_EN) begin
                  state_nx_s = ST_COOL;
                  cnt_nx_s   = CD_LOAD;
               end else begin
                  state_nx_s = ST_IDLE;
                  cnt_nx_s   = 16'd0;
               end
            end else begin
               state_nx_s = ST_EMIT;
            end
         end
         ST_COOL: begin
            drop_s = accept_s;
            if (accept_s && kill_switch) begin
               state_nx_s = ST_HALT;
               cnt_nx_s   = 16'd0;
            end else if (cnt_r <= 16'd1) begin
               // counter reads 1 this cycle: back to IDLE next cycle
               state_nx_s = ST_IDLE;
               cnt_nx_s   = 16'd0;
            end else begin
               cnt_nx_s   = cnt_r - 16'd1;
            end
         end
         ST_HALT: begin
            drop_s = accept_s;
            // a kill beat arriving with clear_halt keeps the halt latched
            if (clear_halt && !(accept_s && kill_switch)) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 16'd0;
         end
      endcase
   end

   // State, order, position registers; handshake flags registered from next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         pos_r       <= 32'sd0;
         side_r      <= 1'b0;
         qty_r       <= 32'd0;
         ord_valid_r <= 1'b0;
         halted_r    <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         pos_r       <= pos_nx_s;
         side_r      <= side_nx_s;
         qty_r       <= qty_nx_s;
         ord_valid_r <= (state_nx_s == ST_EMIT);
         halted_r    <= (state_nx_s == ST_HALT);
         in_ready_r  <= (state_nx_s != ST_EMIT);
      end
   end

`ifdef ORDER_STATS_EN
   logic [15:0] ord_cnt_r;
   logic [15:0] drop_cnt_r;

   assign ord_count  = ord_cnt_r;
   assign drop_count = drop_cnt_r;

   // Saturating counters of completed orders and dropped beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ord_cnt_r  <= 16'd0;
         drop_cnt_r <= 16'd0;
      end else begin
         if (done_s && (ord_cnt_r != 16'hFFFF)) begin
            ord_cnt_r <= ord_cnt_r + 16'd1;
         end else begin
            ord_cnt_r <= ord_cnt_r;
         end
         if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_order_gen.sv
// ---------------------------------------------------------------------------
// tb_order_gen
// Self-checking bench for order_gen: directed scenarios followed by random
// traffic, compared cycle by cycle with an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_order_gen;

   localparam longint TH  = 32768;
   localparam longint Q   = 65536;
   localparam longint LIM = 655360;
   localparam int     CD  = 4;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] signal_in;
   logic               allow_trade;
   logic               kill_switch;
   logic               ord_valid;
   logic               ord_ready;
   logic               ord_side;
   logic        [31:0] ord_qty;
   logic signed [31:0] position_out;
   logic               halted;
   logic               clear_halt;
`ifdef ORDER_STATS_EN
   logic        [15:0] ord_count;
   logic        [15:0] drop_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit          m_emit;
   bit          m_halt;
   int          m_cd;
   longint      m_pos;
   bit          m_side;
   logic [31:0] m_qty;
   int          m_ord;
   int          m_drop;

   order_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .signal_in    (signal_in),
      .allow_trade  (allow_trade),
      .kill_switch  (kill_switch),
      .ord_valid    (ord_valid),
      .ord_ready    (ord_ready),
      .ord_side     (ord_side),
      .ord_qty      (ord_qty),
      .position_out (position_out),
      .halted       (halted),
      .clear_halt   (clear_halt)
`ifdef ORDER_STATS_EN
      ,
      .ord_count    (ord_count),
      .drop_count   (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_emit = 1'b0;
      m_halt = 1'b0;
      m_cd   = 0;
      m_pos  = 0;
      m_side = 1'b0;
      m_qty  = 32'd0;
      m_ord  = 0;
      m_drop = 0;
   endtask

   // advance the model by one clock using the currently driven inputs
   task automatic model_step();
      bit     acc;
      longint s;
      acc = in_valid && !m_emit;
      s   = signal_in;
      if (m_halt) begin
         if (acc) m_drop++;
         if (clear_halt && !(acc && kill_switch)) m_halt = 1'b0;
      end else if (m_emit) begin
         if (ord_ready) begin
            m_pos  = m_side ? m_pos + Q : m_pos - Q;
            m_emit = 1'b0;
            m_cd   = CD;
            m_ord++;
         end
      end else if (m_cd > 0) begin
         if (acc) m_drop++;
         if (acc && kill_switch) begin
            m_halt = 1'b1;
            m_cd   = 0;
         end else begin
            m_cd--;
         end
      end else if (acc) begin
         if (kill_switch) begin
            m_halt = 1'b1;
            m_drop++;
         end else if (allow_trade && s > TH && m_pos + Q <= LIM) begin
            m_emit = 1'b1; m_side = 1'b1; m_qty = 32'(Q);
         end else if (allow_trade && s < -TH && m_pos - Q >= -LIM) begin
            m_emit = 1'b1; m_side = 1'b0; m_qty = 32'(Q);
         end else begin
            m_drop++;
         end
      end
   endtask

   task automatic check_all();
      check("ord_valid", 32'(ord_valid), 32'(m_emit));
      check("in_ready",  32'(in_ready),  32'(!m_emit));
      check("halted",    32'(halted),    32'(m_halt));
      check("position",  position_out,   32'(m_pos));
      check("ord_side",  32'(ord_side),  32'(m_side));
      check("ord_qty",   ord_qty,        m_qty);
`ifdef ORDER_STATS_EN
      check("ord_count",  32'(ord_count),  32'((m_ord  > 65535) ? 65535 : m_ord));
      check("drop_count", 32'(drop_count), 32'((m_drop > 65535) ? 65535 : m_drop));
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic step(input bit v, input logic [31:0] s, input bit a, input bit k,
                       input bit r, input bit c);
      in_valid    = v;
      signal_in   = s;
      allow_trade = a;
      kill_switch = k;
      ord_ready   = r;
      clear_halt  = c;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // asynchronous reset applied between clock edges
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ord_valid", 32'(ord_valid), 32'd0);
      check("rst_position",  position_out,   32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] sv;
      logic [31:0] held_qty;
      logic        held_side;
      rst_n = 1'b0; in_valid = 1'b0; signal_in = 32'd0; allow_trade = 1'b0;
      kill_switch = 1'b0; ord_ready = 1'b1; clear_halt = 1'b0;
      model_reset();
      #3;
      check("reset_ord_valid", 32'(ord_valid), 32'd0);
      check("reset_ord_qty",   ord_qty,        32'd0);
      check("reset_ord_side",  32'(ord_side),  32'd0);
      check("reset_position",  position_out,   32'd0);
      check("reset_halted",    32'(halted),    32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // buy beat, handshake, then 4 dropped beats and acceptance on the 5th
      step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("buy_valid", 32'(ord_valid), 32'd1);
      check("buy_side",  32'(ord_side),  32'd1);
      check("buy_qty",   ord_qty,        32'h0001_0000);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("buy_pos", position_out, 32'h0001_0000);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
         check("cool_drop", 32'(ord_valid), 32'd0);
      end
      step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      check("cool_end_accept", 32'(ord_valid), 32'd1);

      // backpressure on the pending order
      held_qty  = ord_qty;
      held_side = ord_side;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
         check("bp_valid", 32'(ord_valid), 32'd1);
         check("bp_ready", 32'(in_ready),  32'd0);
         check("bp_qty",   ord_qty,        held_qty);
         check("bp_side",  32'(ord_side),  32'(held_side));
      end
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("bp_pos", position_out, 32'h0002_0000);
      idle(6);

      // threshold boundary and allow_trade
      do_reset();
      step(1'b1, 32'h0000_8000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("thr_eq_noorder", 32'(ord_valid), 32'd0);
      step(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("sell_valid", 32'(ord_valid), 32'd1);
      check("sell_side",  32'(ord_side),  32'd0);
      idle(1);
      check("sell_pos", position_out, 32'hFFFF_0000);
      idle(5);
      step(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      check("disallow_noorder", 32'(ord_valid), 32'd0);

      // position limit
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
         idle(6);
      end
      check("limit_pos", position_out, 32'h000A_0000);
      step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("limit_noorder", 32'(ord_valid), 32'd0);
      check("limit_pos_hold", position_out, 32'h000A_0000);
      step(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("limit_sell", 32'(ord_valid), 32'd1);
      idle(6);

      // reset mid-order: order abandoned, position cleared
      step(1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_emit_valid", 32'(ord_valid), 32'd1);
      do_reset();

      // kill switch and halt release
      step(1'b1, 32'h0002_0000, 1'b1, 1'b1, 1'b1, 1'b0);
      check("kill_halted", 32'(halted),    32'd1);
      check("kill_noorder", 32'(ord_valid), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("halt_drop", 32'(ord_valid), 32'd0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("clear_release", 32'(halted), 32'd0);
      step(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("clear_with_kill", 32'(halted), 32'd1);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("clear_again", 32'(halted), 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 6))
            0: sv = 32'h0000_8000;
            1: sv = 32'h0000_8001;
            2: sv = 32'hFFFF_8000;
            3: sv = 32'hFFFF_7FFF;
            4: sv = 32'h0001_0000;
            5: sv = 32'hFFFF_0000;
            default: sv = $urandom;
         endcase
         step(1'($urandom_range(0, 1)), sv, 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
